siphash_core: RTL

- Sequencing stage wrapped around the existing `round` block: it feeds `round`'s iv0..iv3 inputs and consumes its ov0..ov3 outputs.
- Owns the SipHash state v0..v3, key initialisation, message absorption, length padding and finalisation.
- Produces one 64-bit SipHash-c-d tag per message.
- Sits between the message word stream from upstream and the tag consumer.

---
 rtl/siphash_core.sv | 266 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/siphash_core.sv
// SipHash-c-d sequencing core: key setup, word absorption, length padding
// and finalisation around a one-round-per-cycle SipRound engine.

// One SipRound per clock: the engine registers its input vector and presents
// the rounded result combinationally, so feeding ov back into iv advances one
// round per edge.
module siphash_round (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [63:0] iv0,
  input  logic [63:0] iv1,
  input  logic [63:0] iv2,
  input  logic [63:0] iv3,
  output logic [63:0] ov0,
  output logic [63:0] ov1,
  output logic [63:0] ov2,
  output logic [63:0] ov3
);

  logic [63:0] s0_q, s1_q, s2_q, s3_q;

  function automatic logic [63:0] rotl(input logic [63:0] x, input int r);
    return (x << r) | (x >> (64 - r));
  endfunction

  // Capture the vector to be rounded on every edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s0_q <= '0;
      s1_q <= '0;
      s2_q <= '0;
      s3_q <= '0;
    end else begin
      s0_q <= iv0;
      s1_q <= iv1;
      s2_q <= iv2;
      s3_q <= iv3;
    end
  end

  // One SipRound (ARX network) applied to the captured vector.
  always_comb begin
    logic [63:0] a0, a1, a2, a3;
    a0 = s0_q;
    a1 = s1_q;
    a2 = s2_q;
    a3 = s3_q;
    a0 = a0 + a1;
    a1 = rotl(a1, 13);
    a1 = a1 ^ a0;
    a0 = rotl(a0, 32);
    a2 = a2 + a3;
    a3 = rotl(a3, 16);
    a3 = a3 ^ a2;
    a0 = a0 + a3;
    a3 = rotl(a3, 21);
    a3 = a3 ^ a0;
    a2 = a2 + a1;
    a1 = rotl(a1, 17);
    a1 = a1 ^ a2;
    a2 = rotl(a2, 32);
    ov0 = a0;
    ov1 = a1;
    ov2 = a2;
    ov3 = a3;
  end

endmodule

module siphash_core #(
  parameter int C_ROUNDS = 2,
  parameter int D_ROUNDS = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [127:0] key,
  output logic         busy,
  input  logic [63:0]  m_data,
  input  logic [2:0]   m_bytes,
  input  logic         m_last,
  input  logic         m_valid,
  output logic         m_ready,
  output logic [63:0]  h_data,
  output logic         h_valid,
  input  logic         h_ready
);

  typedef enum logic [2:0] {
    IDLE,
    ABSORB,
    COMP,
    FINLOAD,
    FIN,
    DONE
  } state_e;

  localparam logic [3:0] CMax = 4'(C_ROUNDS);
  localparam logic [3:0] DMax = 4'(D_ROUNDS);

  state_e      state_q, state_d;
  logic [63:0] v0_q, v1_q, v2_q, v3_q;
  logic [63:0] v0_d, v1_d, v2_d, v3_d;
  logic [63:0] m_q, m_d;
  logic        last_q, last_d;
  logic [7:0]  len_q, len_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [63:0] hData_q, hData_d;
  logic        hValid_q, hValid_d;

  logic [63:0] mWord;
  logic [63:0] roundIv0, roundIv1, roundIv2, roundIv3;
  logic [63:0] roundOv0, roundOv1, roundOv2, roundOv3;

  siphash_round u_round (
    .clk   (clk),
    .rst_n (rst_n),
    .iv0   (roundIv0),
    .iv1   (roundIv1),
    .iv2   (roundIv2),
    .iv3   (roundIv3),
    .ov0   (roundOv0),
    .ov1   (roundOv1),
    .ov2   (roundOv2),
    .ov3   (roundOv3)
  );

  // Form the absorbed word: a final word keeps only its valid bytes and
  // carries the total length (mod 256) in its top byte.
  always_comb begin
    mWord = m_data;
    if (m_last) begin
      for (int i = 0; i < 8; i++) begin
        if (i >= int'(m_bytes)) begin
          mWord[8*i +: 8] = 8'h00;
        end
      end
      mWord[63:56] = len_q + {5'b00000, m_bytes};
    end
  end

  // State, chaining value and tag registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      v0_q     <= '0;
      v1_q     <= '0;
      v2_q     <= '0;
      v3_q     <= '0;
      m_q      <= '0;
      last_q   <= 1'b0;
      len_q    <= '0;
      cnt_q    <= '0;
      hData_q  <= '0;
      hValid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      v0_q     <= v0_d;
      v1_q     <= v1_d;
      v2_q     <= v2_d;
      v3_q     <= v3_d;
      m_q      <= m_d;
      last_q   <= last_d;
      len_q    <= len_d;
      cnt_q    <= cnt_d;
      hData_q  <= hData_d;
      hValid_q <= hValid_d;
    end
  end

  // Sequencing: load the round engine, count rounds, fold results back into v.
  always_comb begin
    state_d  = state_q;
    v0_d     = v0_q;
    v1_d     = v1_q;
    v2_d     = v2_q;
    v3_d     = v3_q;
    m_d      = m_q;
    last_d   = last_q;
    len_d    = len_q;
    cnt_d    = cnt_q;
    hData_d  = hData_q;
    hValid_d = hValid_q;
    roundIv0 = roundOv0;
    roundIv1 = roundOv1;
    roundIv2 = roundOv2;
    roundIv3 = roundOv3;

    case (state_q)
      IDLE: begin
        if (start) begin
          v0_d    = key[63:0]   ^ 64'h736f6d6570736575;
          v1_d    = key[127:64] ^ 64'h646f72616e646f6d;
          v2_d    = key[63:0]   ^ 64'h6c7967656e657261;
          v3_d    = key[127:64] ^ 64'h7465646279746573;
          len_d   = 8'h00;
          state_d = ABSORB;
        end
      end

      ABSORB: begin
        roundIv0 = v0_q;
        roundIv1 = v1_q;
        roundIv2 = v2_q;
        roundIv3 = v3_q ^ mWord;
        if (m_valid) begin
          m_d     = mWord;
          last_d  = m_last;
          cnt_d   = 4'd1;
          state_d = COMP;
          if (!m_last) begin
            len_d = len_q + 8'd8;
          end
        end
      end

      COMP: begin
        if (cnt_q == CMax) begin
          v0_d = roundOv0 ^ m_q;
          v1_d = roundOv1;
          v2_d = roundOv2 ^ (last_q ? 64'h00000000000000ff : 64'h0);
          v3_d = roundOv3;
          state_d = last_q ? FINLOAD : ABSORB;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end

      FINLOAD: begin
        roundIv0 = v0_q;
        roundIv1 = v1_q;
        roundIv2 = v2_q;
        roundIv3 = v3_q;
        cnt_d    = 4'd1;
        state_d  = FIN;
      end

      FIN: begin
        if (cnt_q == DMax) begin
          hData_d  = roundOv0 ^ roundOv1 ^ roundOv2 ^ roundOv3;
          hValid_d = 1'b1;
          state_d  = DONE;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end

      DONE: begin
        if (h_ready) begin
          hValid_d = 1'b0;
          state_d  = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign busy    = (state_q != IDLE);
  assign m_ready = (state_q == ABSORB);
  assign h_data  = hData_q;
  assign h_valid = hValid_q;

endmodule
